stall_unit: RTL and testbench

STALL_UNIT -- requirements
Module: stall_unit

---
 rtl/stall_unit_pkg.sv | 39 +++
 rtl/stall_perf_counters.sv | 49 ++++
 rtl/stall_unit.sv | 78 +++++++
 tb/tb_stall_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stall_unit_pkg.sv
// stall_unit_pkg
// Holds the shared definitions for the stall unit: the sequencer state
// encoding, its width, and the next-state rule used by the top module.
package stall_unit_pkg;

   localparam int STATE_WIDTH = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE = 3'd0,
      FD   = 3'd1,
      DE   = 3'd2,
      EM   = 3'd3,
      MW   = 3'd4
   } state_t;

   // start beats hold. Once out of IDLE the sequencer runs a fixed
   // FD->DE->EM->MW ring and repeats it. Unused encodings fall back to IDLE,
   // even while hold is high, so the unit cannot lock up in one of them.
   function automatic state_t next_state(input state_t cur,
                                         input logic   start,
                                         input logic   hold);
      state_t nxt;
      nxt = cur;
      if (start) begin
         nxt = IDLE;
      end else begin
         case (cur)
            IDLE:    nxt = FD;
            FD:      nxt = hold ? FD : DE;
            DE:      nxt = hold ? DE : EM;
            EM:      nxt = hold ? EM : MW;
            MW:      nxt = hold ? MW : FD;
            default: nxt = IDLE;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/stall_perf_counters.sv
// stall_perf_counters
// Counts performance events for the stall unit. This module is used only in
// builds that define STALL_PERF_EN.
//   clk, reset    : clock and asynchronous active-high reset
//   start         : clears both counters
//   active        : the sequencer is out of IDLE on this edge
//   retire        : the mw enable is high on this edge
//   report        : prints the current counter values, in simulation only
//   phase         : current state, included in the report line
//   cycle_count   : number of edges spent outside IDLE, modulo 2^COUNTER_WIDTH
//   retired_count : number of mw pulses, modulo 2^COUNTER_WIDTH
module stall_perf_counters
   import stall_unit_pkg::*;
#(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     active,
   input  logic                     retire,
   input  logic                     report,
   input  logic [STATE_WIDTH-1:0]   phase,
   output logic [COUNTER_WIDTH-1:0] cycle_count,
   output logic [COUNTER_WIDTH-1:0] retired_count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count   <= '0;
         retired_count <= '0;
      end else if (start) begin
         cycle_count   <= '0;
         retired_count <= '0;
      end else begin
         if (active) cycle_count   <= cycle_count + 1'b1;
         if (retire) retired_count <= retired_count + 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (report)
         $display("stall_unit report: cycles=%0d retired=%0d state=%0d",
                  cycle_count, retired_count, phase);
   end
`endif

endmodule

// File: rtl/stall_unit.sv
// stall_unit
// Sequences a single-issue pipeline with one instruction in flight. Each
// stage register enable pulses once per 4-state instruction. Holding the
// sequencer lengthens the current stage and never repeats an enable.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   start  : program-load / restart; returns the sequencer to IDLE
//   hold   : freezes the sequencer and masks the enables
//   fd, de, em, mw : pipeline register enables (mw also advances the PC)
//   phase  : state register, for debug
// Optional macro STALL_PERF_EN adds these ports:
//   report        : prints the counters in simulation
//   retired_count : number of mw pulses
//   cycle_count   : number of cycles spent outside IDLE
//
// state | meaning
// IDLE  | after reset/start, no instruction in flight
// FD    | fetch->decode transfer
// DE    | decode->execute transfer
// EM    | execute->memory transfer
// MW    | memory->writeback transfer, PC advance
module stall_unit
   import stall_unit_pkg::*;
#(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     hold,
`ifdef STALL_PERF_EN
   input  logic                     report,
   output logic [COUNTER_WIDTH-1:0] retired_count,
   output logic [COUNTER_WIDTH-1:0] cycle_count,
`endif
   output logic                     fd,
   output logic                     de,
   output logic                     em,
   output logic                     mw,
   output logic [STATE_WIDTH-1:0]   phase
);

   if (COUNTER_WIDTH < 1) begin : g_cw_check
      $error("stall_unit: COUNTER_WIDTH must be at least 1");
   end

   state_t state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state(state, start, hold);
   end

   // The enables are decoded straight from the state register, so reset
   // forces them low at once without waiting for a clock edge.
   assign fd    = (state == FD) & ~hold;
   assign de    = (state == DE) & ~hold;
   assign em    = (state == EM) & ~hold;
   assign mw    = (state == MW) & ~hold;
   assign phase = state;

`ifdef STALL_PERF_EN
   stall_perf_counters #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) u_perf (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .active        (state != IDLE),
      .retire        (mw),
      .report        (report),
      .phase         (phase),
      .cycle_count   (cycle_count),
      .retired_count (retired_count)
   );
`endif

endmodule

// File: tb/tb_stall_unit.sv
module tb_stall_unit;

   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       reset, start, hold;
   logic       fd, de, em, mw;
   logic [2:0] phase;
`ifdef STALL_PERF_EN
   logic          report;
   logic [CW-1:0] retired_count, cycle_count;
`endif

   stall_unit #(.COUNTER_WIDTH(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .hold          (hold),
`ifdef STALL_PERF_EN
      .report        (report),
      .retired_count (retired_count),
      .cycle_count   (cycle_count),
`endif
      .fd            (fd),
      .de            (de),
      .em            (em),
      .mw            (mw),
      .phase         (phase)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model. m_stage is the position inside the current
   // instruction: 0 means no instruction is in flight, and 1..4 are the
   // four transfers.
   int m_stage;
   int m_cyc;
   int m_ret;
   int cnt_fd, cnt_de, cnt_em, cnt_mw;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [3:0] exp_enables(input int stage, input logic h);
      logic [3:0] e;
      e = 4'b0000;
      if (!h && stage >= 1 && stage <= 4) e[4 - stage] = 1'b1;
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      check_val({tag, "_phase"}, 32'(phase), 32'(m_stage));
      check_val({tag, "_en"}, 32'({fd, de, em, mw}), 32'(exp_enables(m_stage, hold)));
`ifdef STALL_PERF_EN
      check_val({tag, "_cyc"}, 32'(cycle_count), 32'(m_cyc));
      check_val({tag, "_ret"}, 32'(retired_count), 32'(m_ret));
`endif
   endtask

   // Called at a negedge. Drives the inputs, checks the outputs, lets one
   // rising edge pass, updates the model, and returns at the next negedge.
   task automatic step(input string tag, input logic s, input logic h);
      start = s;
      hold  = h;
      #1;
      check_outputs(tag);
      cnt_fd += int'(fd);
      cnt_de += int'(de);
      cnt_em += int'(em);
      cnt_mw += int'(mw);
      @(posedge clk);
      if (s) begin
         m_cyc = 0;
         m_ret = 0;
      end else begin
         if (m_stage != 0) m_cyc = (m_cyc + 1) % (1 << CW);
         if (m_stage == 4 && !h) m_ret = (m_ret + 1) % (1 << CW);
      end
      if (s)                m_stage = 0;
      else if (m_stage == 0) m_stage = 1;
      else if (!h)          m_stage = (m_stage % 4) + 1;
      @(negedge clk);
   endtask

   task automatic clear_pulses();
      cnt_fd = 0; cnt_de = 0; cnt_em = 0; cnt_mw = 0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0;
`ifdef STALL_PERF_EN
      report = 1'b0;
`endif
      m_stage = 0; m_cyc = 0; m_ret = 0;
      clear_pulses();
      #1;
      check_outputs("reset_init");
      @(negedge clk);
      reset = 1'b0;

      // Basic sequence: start pulse, the IDLE->FD edge, then 8 free cycles.
      step("st", 1'b1, 1'b0);
      step("idle", 1'b0, 1'b0);
      clear_pulses();
      for (int i = 0; i < 8; i++) step("basic", 1'b0, 1'b0);
      check_val("basic_fd_pulses", 32'(cnt_fd), 32'd2);
      check_val("basic_de_pulses", 32'(cnt_de), 32'd2);
      check_val("basic_em_pulses", 32'(cnt_em), 32'd2);
      check_val("basic_mw_pulses", 32'(cnt_mw), 32'd2);

      // Hold for 3 cycles while in EM.
      step("to_de", 1'b0, 1'b0);
      step("to_em", 1'b0, 1'b0);
      clear_pulses();
      for (int i = 0; i < 3; i++) step("hold_em", 1'b0, 1'b1);
      check_val("hold_em_quiet", 32'(cnt_em), 32'd0);
      step("em_go", 1'b0, 1'b0);
      step("mw_go", 1'b0, 1'b0);
      check_val("hold_em_once", 32'(cnt_em), 32'd1);
      check_val("hold_mw_once", 32'(cnt_mw), 32'd1);

      // start has priority over hold while in MW.
      step("to_de2", 1'b0, 1'b0);
      step("to_em2", 1'b0, 1'b0);
      step("to_mw2", 1'b0, 1'b0);
      clear_pulses();
      step("mw_start_hold", 1'b1, 1'b1);
      step("after_start", 1'b0, 1'b0);
      check_val("start_no_mw", 32'(cnt_mw), 32'd0);

      // Asynchronous reset while in DE, checked before the next clock edge.
      step("r_de", 1'b0, 1'b0);
      check_val("pre_reset_phase", 32'(phase), 32'd2);
      reset = 1'b1;
      #1;
      m_stage = 0; m_cyc = 0; m_ret = 0;
      check_outputs("async_reset");
      @(negedge clk);
      check_outputs("reset_held");
      reset = 1'b0;
      step("post_reset_idle", 1'b0, 1'b0);
      step("post_reset_fd", 1'b0, 1'b0);

`ifdef STALL_PERF_EN
      // Counter wrap: 20 cycles outside IDLE give 20 mod 16 = 4.
      step("cw_start", 1'b1, 1'b0);
      step("cw_idle", 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step("cw_run", 1'b0, 1'b0);
      #1;
      check_val("cycle_wrap", 32'(cycle_count), 32'd4);
      check_val("retired_5", 32'(retired_count), 32'd5);
      report = 1'b1;
      step("cw_report", 1'b0, 1'b0);
      report = 1'b0;
      step("cw_clear", 1'b1, 1'b0);
      #1;
      check_val("cycle_cleared", 32'(cycle_count), 32'd0);
      check_val("retired_cleared", 32'(retired_count), 32'd0);
      @(negedge clk);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
